// File: rtl/image_buffer.sv
// Image capture buffer: assembles SPI bytes into a flat image register and
// reports fill status to the controller FSM and the inference core.
module image_buffer #(
  parameter int IMG_BITS = 784,
  localparam int IMG_BYTES = IMG_BITS / 8,
  localparam int CNT_W = $clog2(IMG_BYTES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          data_in,
  input  logic                write_enable,
  input  logic                clear_buffer,
  output logic                buffer_full,
  output logic                buffer_empty,
  output logic                overflow,
  output logic [CNT_W-1:0]    byte_count,
  output logic                img_valid,
  output logic [IMG_BITS-1:0] img_out
);

  localparam int IDX_W = $clog2(IMG_BITS);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMG_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IMG_BYTES);

  if (IMG_BITS % 8 != 0) begin : g_bad_img_bits
    $error("image_buffer: IMG_BITS must be a multiple of 8");
  end

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [IMG_BITS-1:0] img_r, img_s;
  logic [CNT_W-1:0]    count_r, count_s;
  logic                overflow_r, overflow_s;
  logic                full_r, empty_r, valid_r;
  logic [IDX_W-1:0]    base_s;

  assign base_s = IDX_W'({count_r, 3'b000});

  // Next-state and next-contents decode; clear has priority over a write.
  always_comb begin
    state_s    = state_r;
    img_s      = img_r;
    count_s    = count_r;
    overflow_s = overflow_r;
    if (clear_buffer) begin
      state_s    = EMPTY;
      img_s      = {IMG_BITS{1'b0}};
      count_s    = CNT_ZERO;
      overflow_s = 1'b0;
    end else if (write_enable) begin
      case (state_r)
        EMPTY, FILLING: begin
          img_s[base_s +: 8] = data_in;
          count_s            = count_r + CNT_ONE;
          state_s            = (count_r == CNT_LAST) ? FULL : FILLING;
        end
        FULL: begin
          overflow_s = 1'b1;
        end
        default: begin
          state_s = EMPTY;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, contents and status flags, all registered from the same next values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      img_r      <= {IMG_BITS{1'b0}};
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      img_r      <= img_s;
      count_r    <= count_s;
      overflow_r <= overflow_s;
      full_r     <= (count_s == CNT_FULL);
      empty_r    <= (count_s == CNT_ZERO);
      valid_r    <= (state_s == FULL);
    end
  end

  assign img_out      = img_r;
  assign byte_count   = count_r;
  assign overflow     = overflow_r;
  assign buffer_full  = full_r;
  assign buffer_empty = empty_r;
  assign img_valid    = valid_r;

endmodule

// File: tb/tb_image_buffer.sv
// Scoreboard bench for image_buffer: a byte-array model predicts each cycle's
// outputs, a monitor compares them after every clock edge.
module tb_image_buffer;

  localparam int NB  = 98;
  localparam int IMG = 784;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     data_in = 8'h00;
  logic           write_enable = 1'b0;
  logic           clear_buffer = 1'b0;
  logic           buffer_full, buffer_empty, overflow, img_valid;
  logic [6:0]     byte_count;
  logic [IMG-1:0] img_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [IMG-1:0] img;
    int             cnt;
    bit             full;
    bit             empty;
    bit             ovf;
    bit             valid;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  logic [7:0] mem [NB];
  int         cnt;
  bit         ovf;

  image_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .write_enable (write_enable),
    .clear_buffer (clear_buffer),
    .buffer_full  (buffer_full),
    .buffer_empty (buffer_empty),
    .overflow     (overflow),
    .byte_count   (byte_count),
    .img_valid    (img_valid),
    .img_out      (img_out)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [IMG-1:0] got, input logic [IMG-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    cmp("img_out", img_out, e.img);
    cmp("byte_count", IMG'(byte_count), IMG'(e.cnt));
    cmp("buffer_full", IMG'(buffer_full), IMG'(e.full));
    cmp("buffer_empty", IMG'(buffer_empty), IMG'(e.empty));
    cmp("overflow", IMG'(overflow), IMG'(e.ovf));
    cmp("img_valid", IMG'(img_valid), IMG'(e.valid));
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    for (int k = 0; k < NB; k++) e.img[8*k +: 8] = mem[k];
    e.cnt   = cnt;
    e.full  = (cnt == NB);
    e.empty = (cnt == 0);
    e.ovf   = ovf;
    e.valid = (cnt == NB);
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NB; k++) mem[k] = 8'h00;
    cnt = 0;
    ovf = 1'b0;
  endtask

  // One stimulus cycle: drive inputs, advance the model, queue the expectation.
  task automatic step(input bit we, input bit clr, input logic [7:0] d);
    @(negedge clk);
    write_enable = we;
    clear_buffer = clr;
    data_in      = d;
    if (clr) begin
      model_reset();
    end else if (we) begin
      if (cnt == NB) ovf = 1'b1;
      else begin
        mem[cnt] = d;
        cnt++;
      end
    end
    q.push_back(snapshot());
  endtask

  // Monitor: after each edge, compare DUT outputs with the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check_all(mon_e);
    end
  end

  initial begin
    model_reset();
    #12;
    check_all(snapshot());
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NB; k++) step(1'b1, 1'b0, 8'(k));
    step(1'b1, 1'b0, 8'hFF);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 8'hA5);
      step(1'b0, 1'b0, 8'($urandom));
      step(1'b0, 1'b0, 8'($urandom));
    end
    step(1'b1, 1'b1, 8'h3C);
    step(1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 40; k++) step(1'b1, 1'b0, 8'($urandom));
    step(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all(snapshot());
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0, 8'($urandom));
    step(1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
